// File: rtl/cdb_pkg.sv
// Shared CDB definitions: default widths, lane count and the broadcast entry format
// used by the arbiter, the reservation stations and the ROB.
package cdb_pkg;

    localparam int CDB_ROB_IDX_W = 4;
    localparam int CDB_DATA_W    = 16;
    localparam int CDB_LANES     = 4;

    typedef struct packed {
        logic [CDB_ROB_IDX_W-1:0] rob_index;
        logic [CDB_DATA_W-1:0]    result;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_fu_fifo.sv
// Per-unit result FIFO. Read/write pointers carry one extra wrap bit so full and
// empty are told apart without a separate counter.
module cdb_fu_fifo
    import cdb_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = cdb_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   push,
    input  logic   pop,
    input  entry_t wdata,
    output entry_t rdata,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + 1'b1;
            if (pop && !empty)
                rptr <= rptr + 1'b1;
        end
    end

    // Storage needs no reset: only slots between rptr and wptr are ever read as valid.
    always_ff @(posedge clk) begin
        if (push && !full && !flush)
            mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB producer: per-unit result FIFOs, round-robin selection of up to LANES heads per
// cycle, registered broadcast. Optional same-cycle bypass of empty FIFOs: CDB_BYPASS_EN.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_FU     = 6,
    parameter int LANES      = CDB_LANES,
    parameter int FIFO_DEPTH = 4,
    parameter int ROB_IDX_W  = CDB_ROB_IDX_W,
    parameter int DATA_W     = CDB_DATA_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic [NUM_FU-1:0]           fu_valid,
    output logic [NUM_FU-1:0]           fu_ready,
    input  logic [NUM_FU*ROB_IDX_W-1:0] fu_rob_index,
    input  logic [NUM_FU*DATA_W-1:0]    fu_result,
    output logic [LANES-1:0]            cdb_valid,
    output logic [LANES*ROB_IDX_W-1:0]  cdb_rob_index,
    output logic [LANES*DATA_W-1:0]     cdb_result
);

    localparam int PTR_W = $clog2(NUM_FU);
    localparam int CNT_W = $clog2(LANES + 1);

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_index;
        logic [DATA_W-1:0]    result;
    } entry_t;

    entry_t              fu_entry   [NUM_FU];
    entry_t              fifo_head  [NUM_FU];
    entry_t              cand_entry [NUM_FU];
    logic [NUM_FU-1:0]   full, empty, cand, grant, push, pop;

    logic [PTR_W-1:0]    rr_ptr, last, idx;
    logic [CNT_W-1:0]    n;
    logic [LANES-1:0]    lane_vld;
    entry_t              lane_ent [LANES];

    logic [LANES-1:0]    cdb_vld_q;
    entry_t              cdb_q [LANES];

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        assign fu_entry[i].rob_index = fu_rob_index[i*ROB_IDX_W +: ROB_IDX_W];
        assign fu_entry[i].result    = fu_result[i*DATA_W +: DATA_W];
`ifdef CDB_BYPASS_EN
        // An empty FIFO with a live input competes directly; if it wins, skip the write.
        assign cand[i]       = ~empty[i] | fu_valid[i];
        assign cand_entry[i] = empty[i] ? fu_entry[i] : fifo_head[i];
        assign push[i]       = fu_valid[i] & ~full[i] & ~flush & ~(empty[i] & grant[i]);
`else
        assign cand[i]       = ~empty[i];
        assign cand_entry[i] = fifo_head[i];
        assign push[i]       = fu_valid[i] & ~full[i] & ~flush;
`endif
        assign pop[i]      = grant[i] & ~empty[i];
        assign fu_ready[i] = ~full[i];

        cdb_fu_fifo #(
            .DEPTH   (FIFO_DEPTH),
            .entry_t (entry_t)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .push  (push[i]),
            .pop   (pop[i]),
            .wdata (fu_entry[i]),
            .rdata (fifo_head[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

    // Walk units from rr_ptr, packing the first LANES candidates onto lanes in order.
    always_comb begin
        grant    = '0;
        lane_vld = '0;
        for (int l = 0; l < LANES; l++)
            lane_ent[l] = '0;
        n    = '0;
        last = rr_ptr;
        idx  = rr_ptr;
        for (int k = 0; k < NUM_FU; k++) begin
            if (cand[idx] && (n < CNT_W'(LANES))) begin
                grant[idx] = 1'b1;
                for (int l = 0; l < LANES; l++) begin
                    if (n == CNT_W'(l)) begin
                        lane_vld[l] = 1'b1;
                        lane_ent[l] = cand_entry[idx];
                    end
                end
                last = idx;
                n    = n + 1'b1;
            end
            idx = (idx == PTR_W'(NUM_FU - 1)) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            cdb_vld_q <= '0;
            for (int l = 0; l < LANES; l++)
                cdb_q[l] <= '0;
        end else if (flush) begin
            cdb_vld_q <= '0;
            for (int l = 0; l < LANES; l++)
                cdb_q[l] <= '0;
        end else begin
            cdb_vld_q <= lane_vld;
            for (int l = 0; l < LANES; l++)
                cdb_q[l] <= lane_ent[l];
            if (|grant)
                rr_ptr <= (last == PTR_W'(NUM_FU - 1)) ? '0 : last + 1'b1;
        end
    end

    assign cdb_valid = cdb_vld_q;
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign cdb_rob_index[l*ROB_IDX_W +: ROB_IDX_W] = cdb_q[l].rob_index;
        assign cdb_result[l*DATA_W +: DATA_W]          = cdb_q[l].result;
    end

endmodule
